// File: rtl/scratchmem_initiator128.sv
// scratchmem_initiator128: 128-bit tid/cid-tagged bus initiator for single-beat
// writes and held-address burst reads, with per-beat ack timeout.
`default_nettype none

module scratchmem_initiator128 #(
    parameter logic [3:0] CID     = 4'd1,
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_we_i,
    input  logic         cmd_cfg_i,
    input  logic [31:0]  cmd_adr_i,
    input  logic [5:0]   cmd_blen_i,

    input  logic         wdat_valid_i,
    output logic         wdat_ready_o,
    input  logic [127:0] wdat_i,
    input  logic [15:0]  wsel_i,

    output logic         rdat_valid_o,
    output logic [127:0] rdat_o,
    output logic         rdat_last_o,

    output logic         done_o,
    output logic         err_o,

    output logic         cs_ram_o,
    output logic         cs_config_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [15:0]  sel_o,
    output logic [31:0]  adr_o,
    output logic [127:0] dat_o,
    output logic [5:0]   blen_o,
    output logic [2:0]   cti_o,
    output logic [7:0]   tid_o,
    output logic [3:0]   cid_o,

    input  logic         ack_i,
    input  logic [127:0] dat_i,
    input  logic [7:0]   tid_i,
    input  logic [3:0]   cid_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOAD = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]   state;
    logic         we_r;
    logic         cfg_r;
    logic [31:0]  adr_r;
    logic [5:0]   blen_r;
    logic [7:0]   tid_r;
    logic [7:0]   tid_cnt;
    logic [5:0]   beat;
    logic [7:0]   timer;
    logic         err_r;
    logic [127:0] dat_r;
    logic [15:0]  sel_r;

    logic in_req;
    logic in_cyc;
    logic ack_ok;
    logic last_beat;

    assign in_req    = (state == S_REQ);
    assign in_cyc    = (state == S_WLOAD) || (state == S_REQ) || (state == S_GAP);
    assign ack_ok    = in_req && ack_i && (tid_i == tid_r) && (cid_i == CID);
    assign last_beat = (beat == blen_r);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            we_r    <= 1'b0;
            cfg_r   <= 1'b0;
            adr_r   <= 32'd0;
            blen_r  <= 6'd0;
            tid_r   <= 8'd0;
            tid_cnt <= 8'd0;
            beat    <= 6'd0;
            timer   <= 8'd0;
            err_r   <= 1'b0;
            dat_r   <= 128'd0;
            sel_r   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        we_r    <= cmd_we_i;
                        cfg_r   <= cmd_cfg_i;
                        adr_r   <= cmd_adr_i & 32'hFFFF_FFF0;
                        blen_r  <= cmd_blen_i;
                        tid_r   <= tid_cnt;
                        tid_cnt <= tid_cnt + 8'd1;
                        beat    <= 6'd0;
                        timer   <= 8'd0;
                        err_r   <= 1'b0;
                        state   <= cmd_we_i ? S_WLOAD : S_REQ;
                    end
                end
                S_WLOAD: begin
                    if (wdat_valid_i) begin
                        dat_r <= wdat_i;
                        sel_r <= wsel_i;
                        timer <= 8'd0;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A valid ack takes priority over timer expiry on the same cycle.
                    if (ack_ok) begin
                        timer <= 8'd0;
                        if (we_r) begin
                            state <= S_GAP;
                        end else if (last_beat) begin
                            state <= S_DONE;
                        end else begin
                            beat <= beat + 6'd1;
                        end
                    end else if (timer == (TIMEOUT - 8'd1)) begin
                        err_r <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_GAP: begin
                    adr_r <= adr_r + 32'd16;
                    if (last_beat) begin
                        state <= S_DONE;
                    end else begin
                        beat  <= beat + 6'd1;
                        state <= S_WLOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is masked while reset is held so no command slips in during reset.
    assign cmd_ready_o  = (state == S_IDLE) && rst_i;
    assign wdat_ready_o = (state == S_WLOAD) && wdat_valid_i;

    assign rdat_valid_o = ack_ok && !we_r;
    assign rdat_o       = rdat_valid_o ? dat_i : 128'd0;
    assign rdat_last_o  = rdat_valid_o && last_beat;

    assign done_o = (state == S_DONE);
    assign err_o  = (state == S_DONE) && err_r;

    assign cyc_o       = in_cyc;
    assign stb_o       = in_req;
    assign cs_ram_o    = in_cyc && !cfg_r;
    assign cs_config_o = in_cyc && cfg_r;
    assign we_o        = in_cyc && we_r;
    assign sel_o       = !in_cyc ? 16'd0 : (we_r ? sel_r : 16'hFFFF);
    assign adr_o       = adr_r;
    assign dat_o       = dat_r;
    assign blen_o      = in_cyc ? blen_r : 6'd0;
    assign cti_o       = (in_cyc && !we_r && (blen_r != 6'd0)) ? 3'b010 : 3'b000;
    assign tid_o       = tid_r;
    assign cid_o       = CID;

endmodule

`default_nettype wire

// File: tb/tb_scratchmem_initiator128.sv
// tb_scratchmem_initiator128: directed stimulus with queue-based scoreboard
// for read beats, write strobes and command completions.
`default_nettype none

module tb_scratchmem_initiator128;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_we = 1'b0;
    logic         cmd_cfg = 1'b0;
    logic [31:0]  cmd_adr = 32'd0;
    logic [5:0]   cmd_blen = 6'd0;
    logic         wdat_valid = 1'b0;
    logic [127:0] wdat = 128'd0;
    logic [15:0]  wsel = 16'd0;
    logic         ack = 1'b0;
    logic [127:0] rsp_dat = 128'd0;
    logic [7:0]   rsp_tid = 8'd0;
    logic [3:0]   rsp_cid = 4'd0;

    logic         cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_last_o;
    logic [127:0] rdat_o, dat_o;
    logic         done_o, err_o, cs_ram_o, cs_config_o, cyc_o, stb_o, we_o;
    logic [15:0]  sel_o;
    logic [31:0]  adr_o;
    logic [5:0]   blen_o;
    logic [2:0]   cti_o;
    logic [7:0]   tid_o;
    logic [3:0]   cid_o;

    scratchmem_initiator128 #(.CID(4'd1), .TIMEOUT(8'd64)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_cfg_i(cmd_cfg), .cmd_adr_i(cmd_adr), .cmd_blen_i(cmd_blen),
        .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat), .wsel_i(wsel),
        .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_last_o(rdat_last_o),
        .done_o(done_o), .err_o(err_o),
        .cs_ram_o(cs_ram_o), .cs_config_o(cs_config_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .dat_o(dat_o), .blen_o(blen_o), .cti_o(cti_o), .tid_o(tid_o), .cid_o(cid_o),
        .ack_i(ack), .dat_i(rsp_dat), .tid_i(rsp_tid), .cid_i(rsp_cid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_tid = 8'd0;

    logic [127:0] rdq_dat[$];
    bit           rdq_last[$];
    bit           doneq_err[$];
    logic [31:0]  wq_adr[$];
    logic [127:0] wq_dat[$];
    logic [15:0]  wq_sel[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit we, input bit cfg, input logic [31:0] a, input logic [5:0] bl);
        int n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_cfg = cfg; cmd_adr = a; cmd_blen = bl;
        while (!cmd_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("cmd_ready_wait", {127'd0, cmd_ready_o}, 128'd1);
        tick();
        cmd_valid = 1'b0;
        chk("tid_o", {120'd0, tid_o}, {120'd0, exp_tid});
        exp_tid = exp_tid + 8'd1;
    endtask

    task automatic do_ack(input logic [7:0] t, input logic [3:0] c, input logic [127:0] d);
        ack = 1'b1; rsp_tid = t; rsp_cid = c; rsp_dat = d;
        tick();
        ack = 1'b0; rsp_dat = 128'd0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat, strobe or completion.
    logic prev_stb = 1'b0;
    always @(negedge clk) begin
        if (rdat_valid_o) begin
            if (rdq_dat.size() == 0) begin
                chk("rdat_unexpected", {127'd0, rdat_valid_o}, 128'd0);
            end else begin
                chk("rdat_data", rdat_o, rdq_dat.pop_front());
                chk("rdat_last", {127'd0, rdat_last_o}, {127'd0, rdq_last.pop_front()});
            end
        end
        if (stb_o && !prev_stb && we_o) begin
            if (wq_adr.size() == 0) begin
                chk("wstb_unexpected", {127'd0, stb_o}, 128'd0);
            end else begin
                chk("wr_adr", {96'd0, adr_o}, {96'd0, wq_adr.pop_front()});
                chk("wr_dat", dat_o, wq_dat.pop_front());
                chk("wr_sel", {112'd0, sel_o}, {112'd0, wq_sel.pop_front()});
            end
        end
        if (done_o) begin
            if (doneq_err.size() == 0) begin
                chk("done_unexpected", {127'd0, done_o}, 128'd0);
            end else begin
                chk("done_err", {127'd0, err_o}, {127'd0, doneq_err.pop_front()});
            end
        end
        prev_stb = stb_o;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [127:0] d;
        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", {127'd0, cmd_ready_o}, 128'd0);
        chk("rst_cyc", {127'd0, cyc_o}, 128'd0);
        chk("rst_cid", {124'd0, cid_o}, 128'd1);
        chk("rst_tid", {120'd0, tid_o}, 128'd0);
        rst = 1'b1;
        tick();
        chk("idle_cmd_ready", {127'd0, cmd_ready_o}, 128'd1);

        // Single write, ack 16 cycles after strobe
        doneq_err.push_back(1'b0);
        issue(1'b1, 1'b0, 32'h0000_1230, 6'd0);
        chk("wload_cyc", {127'd0, cyc_o}, 128'd1);
        chk("wload_stb", {127'd0, stb_o}, 128'd0);
        d = {16{8'hA5}};
        wdat_valid = 1'b1; wdat = d; wsel = 16'hFFFF;
        wq_adr.push_back(32'h0000_1230); wq_dat.push_back(d); wq_sel.push_back(16'hFFFF);
        #1;
        chk("wdat_ready", {127'd0, wdat_ready_o}, 128'd1);
        tick();
        wdat_valid = 1'b0;
        chk("wr_cti", {125'd0, cti_o}, 128'd0);
        chk("wr_cs_ram", {127'd0, cs_ram_o}, 128'd1);
        repeat (15) tick();
        do_ack(8'd0, 4'd1, 128'd0);
        chk("gap_stb", {127'd0, stb_o}, 128'd0);
        chk("gap_cyc", {127'd0, cyc_o}, 128'd1);
        tick();
        chk("wr_done", {127'd0, done_o}, 128'd1);
        tick();
        chk("ready_after_done", {127'd0, cmd_ready_o}, 128'd1);

        // 4-beat RAM read
        doneq_err.push_back(1'b0);
        for (int b = 1; b <= 4; b++) begin
            rdq_dat.push_back(128'(b));
            rdq_last.push_back(b == 4);
        end
        issue(1'b0, 1'b0, 32'h0000_2000, 6'd3);
        chk("rd_cti", {125'd0, cti_o}, 128'd2);
        chk("rd_blen", {122'd0, blen_o}, 128'd3);
        chk("rd_adr", {96'd0, adr_o}, 128'h2000);
        chk("rd_sel", {112'd0, sel_o}, 128'hFFFF);
        do_ack(8'd1, 4'd1, 128'd1);
        tick();
        do_ack(8'd1, 4'd1, 128'd2);
        do_ack(8'd1, 4'd1, 128'd3);
        chk("rd_adr_held", {96'd0, adr_o}, 128'h2000);
        do_ack(8'd1, 4'd1, 128'd4);
        chk("rd_done", {127'd0, done_o}, 128'd1);
        tick();

        // 3-beat write with a 5-cycle stall before the last beat
        doneq_err.push_back(1'b0);
        issue(1'b1, 1'b1, 32'h0000_4000, 6'd2);
        for (int b = 0; b < 3; b++) begin
            if (b == 2) begin
                for (int s = 0; s < 5; s++) begin
                    chk("stall_stb", {127'd0, stb_o}, 128'd0);
                    chk("stall_done", {127'd0, done_o}, 128'd0);
                    tick();
                end
            end
            d = {4{32'h1000_0000 + 32'(b)}};
            wdat_valid = 1'b1; wdat = d; wsel = 16'h00FF << b;
            wq_adr.push_back(32'h0000_4000 + 32'(16 * b));
            wq_dat.push_back(d);
            wq_sel.push_back(16'h00FF << b);
            tick();
            wdat_valid = 1'b0;
            chk("wr_cs_cfg", {127'd0, cs_config_o}, 128'd1);
            tick();
            do_ack(8'd2, 4'd1, 128'd0);
            chk("gap3_stb", {127'd0, stb_o}, 128'd0);
            chk("gap3_cyc", {127'd0, cyc_o}, 128'd1);
            tick();
        end
        chk("wr3_done", {127'd0, done_o}, 128'd1);
        tick();

        // Foreign acks ignored; address low bits cleared
        doneq_err.push_back(1'b0);
        rdq_dat.push_back(128'h11); rdq_last.push_back(1'b0);
        rdq_dat.push_back(128'h22); rdq_last.push_back(1'b1);
        issue(1'b0, 1'b0, 32'h0000_300C, 6'd1);
        chk("rd_adr_align", {96'd0, adr_o}, 128'h3000);
        ack = 1'b1; rsp_tid = 8'd4; rsp_cid = 4'd1; rsp_dat = 128'hBAD;
        #1;
        chk("foreign_tid", {127'd0, rdat_valid_o}, 128'd0);
        tick();
        rsp_tid = 8'd3; rsp_cid = 4'd2;
        #1;
        chk("foreign_cid", {127'd0, rdat_valid_o}, 128'd0);
        tick();
        ack = 1'b0;
        do_ack(8'd3, 4'd1, 128'h11);
        do_ack(8'd3, 4'd1, 128'h22);
        tick();

        // Timeout: done exactly 64 cycles after REQ entry
        doneq_err.push_back(1'b1);
        issue(1'b0, 1'b0, 32'h0000_5000, 6'd0);
        n = 0;
        while (!done_o && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 128'(n), 128'd64);
        chk("timeout_err", {127'd0, err_o}, 128'd1);
        tick();

        // Ack on the expiry cycle wins
        doneq_err.push_back(1'b0);
        rdq_dat.push_back(128'h77); rdq_last.push_back(1'b1);
        issue(1'b0, 1'b0, 32'h0000_5000, 6'd0);
        repeat (63) tick();
        chk("expiry_stb", {127'd0, stb_o}, 128'd1);
        do_ack(8'd5, 4'd1, 128'h77);
        chk("expiry_done", {127'd0, done_o}, 128'd1);
        chk("expiry_err", {127'd0, err_o}, 128'd0);
        tick();

        // Reset mid-burst
        rdq_dat.push_back(128'd1); rdq_last.push_back(1'b0);
        issue(1'b0, 1'b0, 32'h0000_6000, 6'd3);
        do_ack(8'd6, 4'd1, 128'd1);
        rst = 1'b0;
        tick();
        chk("rst_mid_cyc", {127'd0, cyc_o}, 128'd0);
        chk("rst_mid_stb", {127'd0, stb_o}, 128'd0);
        chk("rst_mid_tid", {120'd0, tid_o}, 128'd0);
        chk("rst_mid_ready", {127'd0, cmd_ready_o}, 128'd0);
        tick();
        rst = 1'b1;
        exp_tid = 8'd0;
        #1;
        chk("rst_rel_ready", {127'd0, cmd_ready_o}, 128'd1);
        tick();

        // Tid counter restarts from zero after reset
        doneq_err.push_back(1'b0);
        rdq_dat.push_back(128'h99); rdq_last.push_back(1'b1);
        issue(1'b0, 1'b0, 32'h0000_7000, 6'd0);
        chk("post_rst_cti", {125'd0, cti_o}, 128'd0);
        do_ack(8'd0, 4'd1, 128'h99);
        tick();
        repeat (3) tick();

        chk("rdq_empty", 128'(rdq_dat.size()), 128'd0);
        chk("wq_empty", 128'(wq_adr.size()), 128'd0);
        chk("doneq_empty", 128'(doneq_err.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
